// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: holds a real sample and walks the
// DAC code MSB-first against the fed-back DAC voltage, publishing the result with a done pulse.
module sar_adc_ctrl #(
  parameter int  N    = 3,
  parameter real VSUP = 1.0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  real          vin,
  input  real          vdac,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] dout
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(N + 1);
  localparam int FULL = 1 << N;
  localparam logic [N-1:0] MSB_CODE = N'(1) << (N - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  logic [0:0]      state_q;
  logic [N-1:0]    dac_code_q;
  logic [N-1:0]    dout_q;
  logic [IDXW-1:0] idx_q;
  logic            busy_q;
  logic            done_q;
  real             vin_s_q;

  // Candidate next codes for a "keep" (hi) or "drop" (lo) decision on bit idx;
  // the next lower bit is trialled at 1 in both cases.
  logic [N-1:0] code_hi;
  logic [N-1:0] code_lo;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign code_hi[gi] = (int'(idx_q) == gi)     ? 1'b1 :
                           (int'(idx_q) == gi + 1) ? 1'b1 : dac_code_q[gi];
      assign code_lo[gi] = (int'(idx_q) == gi)     ? 1'b0 :
                           (int'(idx_q) == gi + 1) ? 1'b1 : dac_code_q[gi];
    end
  endgenerate

  // The comparator lives here so the DAC feedback path always ends in a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dac_code_q <= '0;
      dout_q     <= '0;
      idx_q      <= IDXW'(N - 1);
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vin_s_q    <= 0.0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            vin_s_q    <= vin;
            dac_code_q <= MSB_CODE;
            idx_q      <= IDXW'(N - 1);
            busy_q     <= 1'b1;
            state_q    <= S_CONV;
          end
        end
        default: begin
          dac_code_q <= (vin_s_q >= vdac) ? code_hi : code_lo;
          if (idx_q != '0) begin
            idx_q <= idx_q - 1'b1;
          end else begin
            dout_q  <= (vin_s_q >= vdac) ? code_hi : code_lo;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign dac_code = dac_code_q;
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Reference result for an ideal linear DAC, used only by the properties below.
  real          scaled;
  logic [N-1:0] ideal_code;

  always_comb begin
    scaled = vin_s_q * real'(FULL) / VSUP;
    if (scaled < 1.0) begin
      ideal_code = '0;
    end else if (scaled >= real'(FULL - 1)) begin
      ideal_code = '1;
    end else begin
      ideal_code = N'($rtoi(scaled));
    end
  end

  logic [CNTW-1:0] busy_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_q <= '0;
    end else if (busy_q) begin
      busy_cnt_q <= busy_cnt_q + 1'b1;
    end else begin
      busy_cnt_q <= '0;
    end
  end

  a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));
  a_result     : assert property (@(posedge clk) disable iff (!rst_n) done_q |-> (dout_q == ideal_code));
  a_busy_len   : assert property (@(posedge clk) disable iff (!rst_n) done_q |-> (busy_cnt_q == CNTW'(N)));

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with an ideal 3-bit DAC in the feedback loop.
module tb_sar_adc_ctrl;

  localparam real VSUP = 1.0;

  logic       clk;
  logic       rst_n;
  logic       start;
  real        vin;
  real        vdac;
  logic [2:0] dac_code;
  logic       busy;
  logic       done;
  logic [2:0] dout;

  int vectors = 0;
  int errs    = 0;

  sar_adc_ctrl #(.N(3), .VSUP(VSUP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .vin      (vin),
    .vdac     (vdac),
    .dac_code (dac_code),
    .busy     (busy),
    .done     (done),
    .dout     (dout)
  );

  always_comb vdac = $itor(dac_code) * VSUP / 8.0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_code(input real v);
    real x;
    x = v * 8.0 / VSUP;
    if (x < 1.0) return 0;
    if (x >= 7.0) return 7;
    return $rtoi($floor(x));
  endfunction

  // Full conversion: start pulse, bounded wait for done, check result and pulse width.
  task automatic run_conv(input string tag, input real v, input int exp);
    int n;
    start = 1'b1;
    vin   = v;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_dout"}, int'(dout), exp);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    step();
    chk({tag, "_done_pulse"}, int'(done), 0);
    $display("conv %s vin=%f dout=%0d expected=%0d", tag, v, dout, exp);
  endtask

  initial begin
    int   seen_done;
    int   exp;
    real  v;

    rst_n = 1'b0;
    start = 1'b0;
    vin   = 0.0;
    step();
    step();
    chk("rst_dac_code", int'(dac_code), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dout", int'(dout), 0);
    rst_n = 1'b1;
    step();

    // vin=0.40: trial codes 100, 010, 011 then done with 011
    start = 1'b1;
    vin   = 0.40;
    step();
    start = 1'b0;
    chk("t1_e0_code", int'(dac_code), 4);
    chk("t1_e0_busy", int'(busy), 1);
    step();
    chk("t1_e1_code", int'(dac_code), 2);
    chk("t1_e1_busy", int'(busy), 1);
    step();
    chk("t1_e2_code", int'(dac_code), 3);
    chk("t1_e2_busy", int'(busy), 1);
    chk("t1_e2_done", int'(done), 0);
    step();
    chk("t1_e3_done", int'(done), 1);
    chk("t1_e3_dout", int'(dout), 3);
    chk("t1_e3_busy", int'(busy), 0);
    chk("t1_e3_code", int'(dac_code), 3);
    step();
    chk("t1_after_done", int'(done), 0);
    chk("t1_dout_hold", int'(dout), 3);
    $display("conv t1 vin=0.40 dout=%0d expected=3", dout);

    run_conv("b_half", 0.5, 4);
    run_conv("b_zero", 0.0, 0);
    run_conv("b_095", 0.95, 7);
    run_conv("b_neg", -0.2, 0);
    run_conv("b_over", 1.3, 7);

    // Input moves after the sample is taken
    start = 1'b1;
    vin   = 0.40;
    step();
    start = 1'b0;
    vin   = 0.90;
    step();
    step();
    step();
    chk("hold_done", int'(done), 1);
    chk("hold_dout", int'(dout), 3);
    $display("conv hold vin=0.40->0.90 dout=%0d expected=3", dout);
    step();

    // Start during busy is ignored; start in the done cycle is accepted
    start = 1'b1;
    vin   = 0.70;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    vin   = 0.10;
    step();
    start = 1'b0;
    chk("busy_restart_ignored", int'(busy), 1);
    step();
    chk("re_done", int'(done), 1);
    chk("re_dout", int'(dout), 5);
    $display("conv re vin=0.70 dout=%0d expected=5", dout);
    start = 1'b1;
    vin   = 0.30;
    step();
    start = 1'b0;
    chk("re2_busy", int'(busy), 1);
    chk("re2_done", int'(done), 0);
    chk("re2_code", int'(dac_code), 4);
    chk("re2_dout_hold", int'(dout), 5);
    step();
    step();
    chk("re2_dout_hold_late", int'(dout), 5);
    step();
    chk("re2_final_done", int'(done), 1);
    chk("re2_final_dout", int'(dout), 2);
    $display("conv re2 vin=0.30 dout=%0d expected=2", dout);
    step();

    // Reset after two decision edges
    start = 1'b1;
    vin   = 0.60;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_code", int'(dac_code), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_dout", int'(dout), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) seen_done = 1;
    end
    chk("mid_rst_no_done", seen_done, 0);
    $display("reset mid-conversion dout=%0d busy=%0d", dout, busy);
    run_conv("post_rst", 0.60, 4);

    for (int k = 0; k < 200; k++) begin
      v   = -0.5 + 2.0 * real'(int'($urandom_range(100000, 0))) / 100000.0;
      exp = ref_code(v);
      run_conv("rand", v, exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
